// File: rtl/pipe_stage_skid_if.sv
// Handshake bus between two pipeline stages: upstream in_* side and downstream out_* side.
// The stage register binds to the slave modport; the traffic source/sink binds to master.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, one-entry skid buffer,
// synchronous flush, bubble ctrl zeroing and saturating stall/bubble counters.
module pipe_stage_skid #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                Clk_in,
    input  logic                Rst,
    input  logic                flush,
    pipe_stage_skid_if.slave    bus,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
);
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

    state_t            state;
    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;

    // in_ready depends only on registered state, so out_ready never reaches it combinationally.
    assign bus.in_ready  = !skid_valid;
    assign bus.out_valid = main_valid;
    assign bus.out_ctrl  = main_valid ? main_ctrl : '0;
    assign bus.out_data  = main_data;

    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            // Data registers keep their contents; only valids and ctrl are squashed.
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_ctrl  <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (bus.in_valid) begin
                        main_ctrl  <= bus.in_ctrl;
                        main_data  <= bus.in_data;
                        main_valid <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.in_valid && bus.out_ready) begin
                        main_ctrl <= bus.in_ctrl;
                        main_data <= bus.in_data;
                    end else if (bus.in_valid) begin
                        skid_ctrl  <= bus.in_ctrl;
                        skid_data  <= bus.in_data;
                        skid_valid <= 1'b1;
                        state      <= FULL;
                    end else if (bus.out_ready) begin
                        main_valid <= 1'b0;
                        state      <= EMPTY;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        main_ctrl  <= skid_ctrl;
                        main_data  <= skid_data;
                        skid_valid <= 1'b0;
                        state      <= BUSY;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

    // Counters look at the pre-edge handshake and survive flush.
    always_ff @(posedge Clk_in or posedge Rst) begin
        if (Rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (main_valid && !bus.out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (!main_valid && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: scoreboard queue fed at accept, drained at retire.
module tb_pipe_stage_skid;
    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [CTRL_W-1:0] c;
        logic [DATA_W-1:0] d;
    } exp_t;

    logic             Clk_in = 1'b0;
    logic             Rst    = 1'b1;
    logic             flush  = 1'b0;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t q[$];

    pipe_stage_skid_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    pipe_stage_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .Clk_in     (Clk_in),
        .Rst        (Rst),
        .flush      (flush),
        .bus        (bus),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 Clk_in = ~Clk_in;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk_in);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        bus.in_valid = v;
        bus.in_ctrl  = c;
        bus.in_data  = d;
    endtask

    task automatic reset_phase();
        Rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0);
        step();
        step();
        Rst = 1'b0;
    endtask

    // Expected entries enter the queue at the accepting edge, unless squashed.
    always @(negedge Clk_in)
        if (!Rst && !flush && bus.in_valid && bus.in_ready)
            q.push_back('{c: bus.in_ctrl, d: bus.in_data});

    always @(posedge Rst) q.delete();

    // Monitor: compare every retiring entry; a retire in a flush cycle is still delivered.
    always @(negedge Clk_in) begin
        if (!Rst) begin
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_out: got data %0h with no entry expected", bus.out_data);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data", bus.out_data, e.d);
                    chk("out_ctrl", 32'(bus.out_ctrl), 32'(e.c));
                end
            end
            if (!bus.out_valid)
                chk("bubble_ctrl_zero", 32'(bus.out_ctrl), 32'h0);
            if (flush) q.delete();
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        drive(1'b0, '0, '0);
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_ctrl",  32'(bus.out_ctrl),  32'h0);
        chk("rst_out_data",  bus.out_data,       32'h0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'h1);
        chk("rst_stall",     32'(stall_cnt),     32'h0);
        chk("rst_bubble",    32'(bubble_cnt),    32'h0);

        // Streaming at full rate
        reset_phase();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(i + 1), 32'h10 + 32'(i));
            chk("stream_in_ready", 32'(bus.in_ready), 32'h1);
            step();
            if (i == 0) chk("stream_latency", 32'(bus.out_valid), 32'h1);
        end
        drive(1'b0, '0, '0);
        step();
        chk("stream_stall",  32'(stall_cnt),     32'h0);
        chk("stream_bubble", 32'(bubble_cnt),    32'h1);
        chk("stream_drain",  32'(bus.out_valid), 32'h0);

        // Backpressure into the skid buffer
        reset_phase();
        drive(1'b1, 8'h0A, 32'hA);
        step();
        drive(1'b1, 8'h0B, 32'hB);
        step();
        drive(1'b1, 8'h0C, 32'hC);
        chk("bp_full_in_ready", 32'(bus.in_ready), 32'h0);
        step();
        step();
        chk("bp_hold_in_ready", 32'(bus.in_ready), 32'h0);
        chk("bp_hold_out_data", bus.out_data,      32'hA);
        chk("bp_stall_blocked", 32'(stall_cnt),    32'h3);
        bus.out_ready = 1'b1;
        step();
        chk("bp_unfull_in_ready", 32'(bus.in_ready), 32'h1);
        step();
        drive(1'b0, '0, '0);
        step();
        chk("bp_stall_final", 32'(stall_cnt),     32'h3);
        chk("bp_drained",     32'(bus.out_valid), 32'h0);

        // Flush while FULL, with an entry offered
        reset_phase();
        drive(1'b1, 8'hFF, 32'h1);
        step();
        drive(1'b1, 8'hFF, 32'h2);
        step();
        chk("fl_full", 32'(bus.in_ready), 32'h0);
        flush = 1'b1;
        drive(1'b1, 8'hFF, 32'hD);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        chk("fl_out_valid", 32'(bus.out_valid), 32'h0);
        chk("fl_out_ctrl",  32'(bus.out_ctrl),  32'h0);
        chk("fl_in_ready",  32'(bus.in_ready),  32'h1);
        chk("fl_stall",     32'(stall_cnt),     32'h2);
        chk("fl_bubble",    32'(bubble_cnt),    32'h1);
        bus.out_ready = 1'b1;
        step();
        step();
        chk("fl_stays_empty", 32'(bus.out_valid), 32'h0);
        // Flush coinciding with a retire and a new offer
        drive(1'b1, 8'h33, 32'h20);
        step();
        flush = 1'b1;
        drive(1'b1, 8'h34, 32'h21);
        step();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        chk("fl_retire_empty", 32'(bus.out_valid), 32'h0);
        step();
        chk("fl_drop_offered", 32'(bus.out_valid), 32'h0);

        // Bubble zeroing and idle counting
        reset_phase();
        bus.out_ready = 1'b1;
        drive(1'b1, 8'h81, 32'h55);
        step();
        drive(1'b0, '0, '0);
        chk("bz_ctrl_live", 32'(bus.out_ctrl), 32'h81);
        step();
        chk("bz_valid",   32'(bus.out_valid), 32'h0);
        chk("bz_ctrl",    32'(bus.out_ctrl),  32'h0);
        chk("bz_bubble1", 32'(bubble_cnt),    32'h1);
        step();
        chk("bz_bubble2", 32'(bubble_cnt),    32'h2);
        step();
        chk("bz_bubble3", 32'(bubble_cnt),    32'h3);

        // Stall counter saturation, flush persistence, async clear
        reset_phase();
        drive(1'b1, 8'h07, 32'h77);
        step();
        drive(1'b0, '0, '0);
        repeat (15) step();
        chk("sat_reach15", 32'(stall_cnt), 32'hF);
        repeat (5) step();
        chk("sat_hold15", 32'(stall_cnt), 32'hF);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("sat_after_flush", 32'(stall_cnt),     32'hF);
        chk("sat_flush_empty", 32'(bus.out_valid), 32'h0);
        #2 Rst = 1'b1;
        #1;
        chk("sat_rst_clear", 32'(stall_cnt), 32'h0);
        step();
        Rst = 1'b0;

        // Asynchronous reset between edges while FULL
        drive(1'b1, 8'h11, 32'h1);
        step();
        drive(1'b1, 8'h22, 32'h2);
        step();
        chk("ar_full", 32'(bus.in_ready), 32'h0);
        drive(1'b0, '0, '0);
        #1 Rst = 1'b1;
        #1;
        chk("ar_out_valid", 32'(bus.out_valid), 32'h0);
        chk("ar_out_ctrl",  32'(bus.out_ctrl),  32'h0);
        chk("ar_out_data",  bus.out_data,       32'h0);
        chk("ar_in_ready",  32'(bus.in_ready),  32'h1);
        chk("ar_stall",     32'(stall_cnt),     32'h0);
        Rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 8'h42, 32'h99);
        step();
        drive(1'b0, '0, '0);
        chk("ar_first_accept", 32'(bus.out_valid), 32'h1);
        step();
        chk("ar_retired", 32'(bus.out_valid), 32'h0);

        step();
        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
